// File: rtl/mcm_word_packer.sv
// Reads one MCM packet out of the byte RAM after a done pulse and packs each byte
// triple into two 12-bit orbit words written to the distributor while no LCB is busy.
module mcm_word_packer #(
    parameter int unsigned BYTES     = 24,
    parameter logic [9:0]  BASE_ADDR = 10'd512,
    parameter logic [9:0]  ADDR_STEP = 10'd1,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iDone,
    input  logic [7:0]  iData,
    output logic [7:0]  oRdAddr,
    output logic        oRdEn,
    input  logic        iBusy,
    output logic [11:0] oData,
    output logic [9:0]  oAddr,
    output logic        oWren,
    output logic        oActive,
    output logic        oOverrun
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WAITF, WR0, WR1} state_t;

    localparam logic [7:0] LAST_N = 8'(BYTES);
    localparam logic [7:0] LAT    = 8'(RD_LAT);

    state_t     state, state_nxt;
    logic [7:0] n;
    logic [7:0] lat_cnt;
    logic [7:0] q_r;
    logic [7:0] b0, b1, b2;
    logic [1:0] slot;
    logic       second;
    logic [9:0] word_addr;
    logic       capture;
    logic       last_wr;

    // q is registered locally, so a byte is taken one cycle after it is valid on iData
    assign capture = (state == CAP) && (lat_cnt == LAT);
    assign last_wr = (state == WR1) && (n == LAST_N);

    assign oRdEn   = (state == RD);
    assign oRdAddr = n;
    assign oWren   = (state == WR0) || (state == WR1);
    assign oActive = (state != IDLE) && !last_wr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iDone) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     if (capture) state_nxt = (slot == 2'd2) ? WAITF : RD;
            WAITF:   if (!iBusy) state_nxt = second ? WR1 : WR0;
            WR0:     state_nxt = WAITF;
            WR1:     state_nxt = (n == LAST_N) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            n         <= '0;
            lat_cnt   <= '0;
            q_r       <= '0;
            b0        <= '0;
            b1        <= '0;
            b2        <= '0;
            slot      <= '0;
            second    <= 1'b0;
            word_addr <= BASE_ADDR;
            oData     <= '0;
            oAddr     <= '0;
            oOverrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_r      <= iData;
            // a done that lands while any packet work is pending (final WR1 included) is dropped
            oOverrun <= iDone && (state != IDLE);
            case (state)
                IDLE: begin
                    if (iDone) begin
                        n         <= '0;
                        slot      <= '0;
                        second    <= 1'b0;
                        word_addr <= BASE_ADDR;
                    end
                end
                RD: lat_cnt <= '0;
                CAP: begin
                    if (capture) begin
                        case (slot)
                            2'd0:    b0 <= q_r;
                            2'd1:    b1 <= q_r;
                            default: b2 <= q_r;
                        endcase
                        n    <= n + 8'd1;
                        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                WAITF: begin
                    if (!iBusy) begin
                        oAddr     <= word_addr;
                        word_addr <= word_addr + ADDR_STEP;
                        oData     <= second ? {b1[3:0], b2} : {b0, b1[7:4]};
                    end
                end
                WR0:     second <= 1'b1;
                WR1:     second <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcm_word_packer.sv
// Scoreboard bench: three packer instances (3-byte, 24-byte, 6-byte at top of address space)
// fed by RAM models with two cycles of read latency.
module tb_mcm_word_packer;

    typedef struct packed {
        logic [9:0]  a;
        logic [11:0] d;
    } exp_t;

    localparam int BYV [3] = '{3, 24, 6};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  done, busy, rden, wren, active, ovr;
    logic [7:0]  raddr [3];
    logic [7:0]  rdata [3];
    logic [11:0] wdata [3];
    logic [9:0]  waddr [3];

    logic [7:0]  mem [3][256];
    logic [7:0]  p1 [3];
    logic [7:0]  p2 [3];

    exp_t expq [3][$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nstrobe [3], ovr_cnt [3], rdcnt [3], rd_next [3], first_wr_cyc [3], last_wr_cyc [3];
    logic first_act [3], last_act [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcm_word_packer #(.BYTES(3)) u0 (
        .clk(clk), .reset(rst_n), .iDone(done[0]), .iData(rdata[0]), .oRdAddr(raddr[0]),
        .oRdEn(rden[0]), .iBusy(busy[0]), .oData(wdata[0]), .oAddr(waddr[0]),
        .oWren(wren[0]), .oActive(active[0]), .oOverrun(ovr[0]));

    mcm_word_packer #(.BYTES(24)) u1 (
        .clk(clk), .reset(rst_n), .iDone(done[1]), .iData(rdata[1]), .oRdAddr(raddr[1]),
        .oRdEn(rden[1]), .iBusy(busy[1]), .oData(wdata[1]), .oAddr(waddr[1]),
        .oWren(wren[1]), .oActive(active[1]), .oOverrun(ovr[1]));

    mcm_word_packer #(.BYTES(6), .BASE_ADDR(10'd1022)) u2 (
        .clk(clk), .reset(rst_n), .iDone(done[2]), .iData(rdata[2]), .oRdAddr(raddr[2]),
        .oRdEn(rden[2]), .iBusy(busy[2]), .oData(wdata[2]), .oAddr(waddr[2]),
        .oWren(wren[2]), .oActive(active[2]), .oOverrun(ovr[2]));

    // RAM: q valid two cycles after the rden cycle; junk otherwise to expose mistimed capture
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            p1[i] <= rden[i] ? mem[i][raddr[i]] : 8'h5A;
            p2[i] <= p1[i];
        end
    end
    assign rdata[0] = p2[0];
    assign rdata[1] = p2[1];
    assign rdata[2] = p2[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rden[i]) begin
                chk("rdaddr", 32'(raddr[i]), 32'(rd_next[i]));
                rd_next[i] = (rd_next[i] + 1) % BYV[i];
                rdcnt[i]++;
            end
            if (ovr[i]) ovr_cnt[i]++;
            if (wren[i]) begin
                nstrobe[i]++;
                last_wr_cyc[i] = cyc;
                last_act[i] = active[i];
                if (nstrobe[i] == 1) begin
                    first_wr_cyc[i] = cyc;
                    first_act[i] = active[i];
                end
                chk("rd_wr_excl", 32'(rden[i]), 32'd0);
                if (expq[i].size() == 0) begin
                    chk("spurious_wren", 32'd1, 32'd0);
                end else begin
                    mon_e = expq[i].pop_front();
                    chk("waddr", 32'(waddr[i]), 32'(mon_e.a));
                    chk("wdata", 32'(wdata[i]), 32'(mon_e.d));
                end
            end
        end
    end

    task automatic push(input int i, input logic [9:0] a, input logic [11:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        expq[i].push_back(e);
    endtask

    task automatic push_pkt(input int i);
        logic [7:0] x0, x1, x2;
        for (int j = 0; j < BYV[i] / 3; j++) begin
            x0 = mem[i][3*j];
            x1 = mem[i][3*j+1];
            x2 = mem[i][3*j+2];
            push(i, 10'd512 + 10'(2*j),     {x0, x1[7:4]});
            push(i, 10'd512 + 10'(2*j + 1), {x1[3:0], x2});
        end
    endtask

    task automatic clr(input int i);
        nstrobe[i] = 0;
        ovr_cnt[i] = 0;
        rdcnt[i]   = 0;
    endtask

    task automatic pulse(input int i, output int c);
        @(posedge clk); #1;
        done[i] = 1'b1;
        c = cyc;
        @(posedge clk); #1;
        done[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, input string nm);
        int k = 0;
        while (active[i] && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (active[i]) chk({nm, "_timeout"}, 32'd1, 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int i, input int n, input int budget, input string nm);
        int k = 0;
        while (nstrobe[i] < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (nstrobe[i] < n) chk({nm, "_timeout"}, 32'(nstrobe[i]), 32'(n));
    endtask

    initial begin
        int c0, rel;
        rst_n = 1'b0;
        done  = '0;
        busy  = '0;
        for (int i = 0; i < 3; i++) begin
            clr(i);
            rd_next[i] = 0;
            first_wr_cyc[i] = 0;
            last_wr_cyc[i] = 0;
            for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
        end
        mem[0][0] = 8'hAB; mem[0][1] = 8'hCD; mem[0][2] = 8'hEF;
        for (int j = 0; j < 24; j++) mem[1][j] = 8'(j);
        mem[2][0] = 8'h11; mem[2][1] = 8'h22; mem[2][2] = 8'h33;
        mem[2][3] = 8'h44; mem[2][4] = 8'h55; mem[2][5] = 8'h66;

        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_wren",   32'(wren[i]),   32'd0);
            chk("rst_rden",   32'(rden[i]),   32'd0);
            chk("rst_active", 32'(active[i]), 32'd0);
            chk("rst_ovr",    32'(ovr[i]),    32'd0);
            chk("rst_wdata",  32'(wdata[i]),  32'd0);
            chk("rst_waddr",  32'(waddr[i]),  32'd0);
            chk("rst_raddr",  32'(raddr[i]),  32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 3-byte packet, latency and oActive timing
        clr(0);
        push(0, 10'd512, 12'hABC);
        push(0, 10'd513, 12'hDEF);
        pulse(0, c0);
        wait_idle(0, 100, "s1");
        chk("s1_latency",    32'(first_wr_cyc[0]), 32'(c0 + 1 + 13));
        chk("s1_strobes",    32'(nstrobe[0]),      32'd2);
        chk("s1_act_first",  32'(first_act[0]),    32'd1);
        chk("s1_act_last",   32'(last_act[0]),     32'd0);

        // done coinciding with the final WR1 is an overrun and is dropped
        clr(0);
        push(0, 10'd512, 12'hABC);
        push(0, 10'd513, 12'hDEF);
        pulse(0, c0);
        while (cyc < c0 + 16) begin @(posedge clk); #1; end
        done[0] = 1'b1;
        @(posedge clk); #1;
        done[0] = 1'b0;
        wait_idle(0, 100, "s1b");
        repeat (30) @(posedge clk);
        #1;
        chk("s1b_ovr",     32'(ovr_cnt[0]), 32'd1);
        chk("s1b_strobes", 32'(nstrobe[0]), 32'd2);
        chk("s1b_active",  32'(active[0]),  32'd0);

        // 24-byte packet, RAM[i]=i
        clr(1);
        push_pkt(1);
        pulse(1, c0);
        wait_idle(1, 400, "s2");
        chk("s2_strobes", 32'(nstrobe[1]), 32'd16);
        chk("s2_reads",   32'(rdcnt[1]),   32'd24);

        // busy hold, then busy between the two words of a triple
        clr(1);
        push_pkt(1);
        busy[1] = 1'b1;
        pulse(1, c0);
        repeat (63) @(posedge clk);
        #1;
        chk("s3_hold_nowr", 32'(nstrobe[1]), 32'd0);
        busy[1] = 1'b0;
        rel = cyc;
        wait_cnt(1, 1, 20, "s3a");
        chk("s3_first_after_busy", 32'(first_wr_cyc[1]), 32'(rel + 1));
        busy[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("s3_hold2_nowr", 32'(nstrobe[1]), 32'd1);
        busy[1] = 1'b0;
        rel = cyc;
        wait_cnt(1, 2, 20, "s3b");
        chk("s3_second_after_busy", 32'(last_wr_cyc[1]), 32'(rel + 1));
        wait_idle(1, 400, "s3");
        chk("s3_strobes", 32'(nstrobe[1]), 32'd16);

        // second done 10 cycles after the first
        clr(1);
        push_pkt(1);
        pulse(1, c0);
        while (cyc < c0 + 10) begin @(posedge clk); #1; end
        done[1] = 1'b1;
        @(posedge clk); #1;
        done[1] = 1'b0;
        wait_idle(1, 400, "s4");
        repeat (40) @(posedge clk);
        #1;
        chk("s4_ovr",     32'(ovr_cnt[1]), 32'd1);
        chk("s4_strobes", 32'(nstrobe[1]), 32'd16);
        chk("s4_active",  32'(active[1]),  32'd0);

        // reset after the 5th strobe, then a full restart
        clr(1);
        push_pkt(1);
        pulse(1, c0);
        wait_cnt(1, 5, 200, "s5");
        rst_n = 1'b0;
        #1;
        chk("s5_rst_wren",   32'(wren[1]),   32'd0);
        chk("s5_rst_active", 32'(active[1]), 32'd0);
        chk("s5_rst_wdata",  32'(wdata[1]),  32'd0);
        chk("s5_rst_waddr",  32'(waddr[1]),  32'd0);
        chk("s5_rst_raddr",  32'(raddr[1]),  32'd0);
        expq[1].delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("s5_no_wr_after_rst", 32'(nstrobe[1]), 32'd5);
        clr(1);
        rd_next[1] = 0;
        push_pkt(1);
        pulse(1, c0);
        wait_idle(1, 400, "s5b");
        chk("s5_restart_strobes", 32'(nstrobe[1]), 32'd16);

        // address wrap from 1022
        clr(2);
        push(2, 10'd1022, 12'h112);
        push(2, 10'd1023, 12'h233);
        push(2, 10'd0,    12'h445);
        push(2, 10'd1,    12'h566);
        pulse(2, c0);
        wait_idle(2, 200, "s6");
        repeat (20) @(posedge clk);
        #1;
        chk("s6_strobes", 32'(nstrobe[2]), 32'd4);

        for (int i = 0; i < 3; i++) chk("queue_empty", 32'(expq[i].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
